mem_c_deskew: RTL and testbench



---
 rtl/systolic_pkg.sv | 17 +
 rtl/deskew_lane.sv | 39 +++
 rtl/mem_c_deskew.sv | 113 +++++++++++
 tb/tb_mem_c_deskew.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array edge memories.
// Holds the default geometry, the result lane type and the deskew FSM states.
package systolic_pkg;

  localparam int BITS_AB = 8;
  localparam int DIM     = 8;
  localparam int BITS_C  = 2 * BITS_AB + 8;

  typedef logic signed [BITS_C-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    EMIT
  } deskew_state_t;

endpackage

// File: rtl/deskew_lane.sv
// One result lane delay line: DEPTH registers that advance only on enable.
// With DEPTH=0 the lane is a plain wire to the output stage.
module deskew_lane #(
  parameter int W     = 24,
  parameter int DEPTH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic                i_clr,
  input  logic signed [W-1:0] i_din,
  output logic signed [W-1:0] o_dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst_n, i_en, i_clr};
      assign o_dout   = i_din;
    end else begin : g_chain
      logic signed [W-1:0] r_sr [DEPTH];

      // Clear wipes partial rows so an aborted transaction leaves nothing behind.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < DEPTH; k++) r_sr[k] <= '0;
        end else if (i_clr) begin
          for (int k = 0; k < DEPTH; k++) r_sr[k] <= '0;
        end else if (i_en) begin
          r_sr[0] <= i_din;
          for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
        end
      end

      assign o_dout = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mem_c_deskew.sv
// Re-aligns the diagonally skewed result lanes of the systolic array into whole
// rows of C, emitting one registered row per enabled cycle with its row index.
module mem_c_deskew
  import systolic_pkg::*;
#(
  parameter int BITS_AB = systolic_pkg::BITS_AB,
  parameter int DIM     = systolic_pkg::DIM,
  parameter int BITS_C  = 2 * BITS_AB + 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [BITS_C-1:0] Cin    [DIM],
  output logic signed [BITS_C-1:0] Cout   [DIM],
  output logic [$clog2(DIM)-1:0]   Crow,
  output logic                     Cvalid,
  output logic                     done
);

  localparam int CNT_W = $clog2(2 * DIM - 1);
  localparam int ROW_W = $clog2(DIM);

  localparam logic [CNT_W-1:0] CNT_FIRST_ROW = CNT_W'(DIM - 1);
  localparam logic [CNT_W-1:0] CNT_LAST_ROW  = CNT_W'(2 * DIM - 2);

  deskew_state_t             r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic signed [BITS_C-1:0]  r_cout [DIM];
  logic [ROW_W-1:0]          r_crow;
  logic                      r_cvalid;
  logic                      r_done;

  logic signed [BITS_C-1:0]  w_tap [DIM];
  logic                      w_emit;
  logic [ROW_W-1:0]          w_row;

  // Lane i is presented i cycles late, so it needs DIM-1-i cycles of extra delay.
  generate
    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
      deskew_lane #(
        .W    (BITS_C),
        .DEPTH(DIM - 1 - gi)
      ) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (en),
        .i_clr (clr),
        .i_din (Cin[gi]),
        .o_dout(w_tap[gi])
      );
    end
  endgenerate

  assign w_emit = en && ((r_state == FILL && r_cnt == CNT_FIRST_ROW) || r_state == EMIT);
  assign w_row  = ROW_W'(r_cnt - CNT_FIRST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_cvalid <= 1'b0;
      r_done   <= 1'b0;
    end else if (clr) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_cvalid <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_cvalid <= w_emit;
      r_done   <= 1'b0;
      if (en) begin
        case (r_state)
          IDLE: begin
            r_cnt   <= CNT_W'(1);
            r_state <= FILL;
          end
          FILL: begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_FIRST_ROW) r_state <= EMIT;
          end
          EMIT: begin
            if (r_cnt == CNT_LAST_ROW) begin
              r_cnt   <= '0;
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Row data is not touched by clear: the host keeps the last emitted row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DIM; k++) r_cout[k] <= '0;
      r_crow <= '0;
    end else if (!clr && w_emit) begin
      for (int k = 0; k < DIM; k++) r_cout[k] <= w_tap[k];
      r_crow <= w_row;
    end
  end

  assign Cout   = r_cout;
  assign Crow   = r_crow;
  assign Cvalid = r_cvalid;
  assign done   = r_done;

endmodule

// File: tb/tb_mem_c_deskew.sv
// Directed bench for mem_c_deskew: drives skewed diagonals and checks the
// re-aligned rows, stalls, clear, signed extremes and back-to-back transactions.
module tb_mem_c_deskew;

  localparam int DIM    = 8;
  localparam int BITS_C = 24;
  localparam int ROW_W  = $clog2(DIM);

  logic                     clk;
  logic                     rst_n;
  logic                     en;
  logic                     clr;
  logic signed [BITS_C-1:0] Cin  [DIM];
  logic signed [BITS_C-1:0] Cout [DIM];
  logic [ROW_W-1:0]         Crow;
  logic                     Cvalid;
  logic                     done;

  int compared   = 0;
  int mismatched = 0;

  mem_c_deskew #(
    .BITS_AB(8),
    .DIM    (DIM),
    .BITS_C (BITS_C)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .Cin   (Cin),
    .Cout  (Cout),
    .Crow  (Crow),
    .Cvalid(Cvalid),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag,
               $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // Mode 0: base + r*16 + i. Mode 1: alternating 24-bit signed extremes.
  function automatic int laneVal(input int mode, input int base, input int r, input int i);
    if (mode == 1) return (((r + i) % 2) == 1) ? 8388607 : -8388608;
    return base + r * 16 + i;
  endfunction

  // Drives one cycle of the skewed stream for enabled cycle k, then waits past the edge.
  task automatic applyStimulus(input bit e, input bit c, input int k, input int mode, input int base);
    en  = e;
    clr = c;
    for (int i = 0; i < DIM; i++) begin
      if (!e) Cin[i] = 24'h5A5A5A;
      else if ((k - i) >= 0 && (k - i) < DIM) Cin[i] = BITS_C'(laneVal(mode, base, k - i, i));
      else Cin[i] = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expectRow(input string tag, input int r, input int mode, input int base);
    checkOutput({tag, " valid"}, 32'(Cvalid), 1);
    checkOutput({tag, " row"}, 32'(Crow), r);
    for (int i = 0; i < DIM; i++)
      checkOutput($sformatf("%s r%0d lane%0d", tag, r, i), Cout[i], laneVal(mode, base, r, i));
  endtask

  task automatic stepAndCheck(input string tag, input int k, input int mode, input int base);
    applyStimulus(1'b1, 1'b0, k, mode, base);
    if (k >= DIM - 1) expectRow(tag, k - (DIM - 1), mode, base);
    else checkOutput({tag, " novalid"}, 32'(Cvalid), 0);
    checkOutput($sformatf("%s done k%0d", tag, k), 32'(done), (k == 2 * DIM - 2) ? 1 : 0);
  endtask

  initial begin
    int validCount;
    int doneCount;
    int firstDone;
    int secondDone;

    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    for (int i = 0; i < DIM; i++) Cin[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset then idle
    for (int n = 0; n < 5; n++) applyStimulus(1'b0, 1'b0, 0, 0, 0);
    checkOutput("reset valid", 32'(Cvalid), 0);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset crow", 32'(Crow), 0);
    checkOutput("reset cout0", Cout[0], 0);
    checkOutput("reset cout7", Cout[DIM-1], 0);

    // Full transaction
    for (int k = 0; k < 2 * DIM - 1; k++) stepAndCheck("full", k, 0, 0);
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    checkOutput("full after valid", 32'(Cvalid), 0);
    checkOutput("full after done", 32'(done), 0);
    checkOutput("full after crow", 32'(Crow), 7);

    // Stall after row 3 emits
    for (int k = 0; k <= DIM - 1 + 3; k++) stepAndCheck("stall", k, 0, 0);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b0, 1'b0, 0, 0, 0);
      checkOutput("stall valid", 32'(Cvalid), 0);
      checkOutput("stall done", 32'(done), 0);
      checkOutput("stall crow", 32'(Crow), 3);
      checkOutput("stall cout5", Cout[5], laneVal(0, 0, 3, 5));
    end
    for (int k = DIM + 3; k < 2 * DIM - 1; k++) stepAndCheck("stall resume", k, 0, 0);

    // Signed extremes
    for (int k = 0; k < 2 * DIM - 1; k++) stepAndCheck("extreme", k, 1, 0);

    // Clear after row 2, then a fresh transaction
    for (int k = 0; k <= DIM - 1 + 2; k++) stepAndCheck("preclr", k, 0, 300);
    applyStimulus(1'b1, 1'b1, DIM + 2, 0, 300);
    checkOutput("clr valid", 32'(Cvalid), 0);
    checkOutput("clr done", 32'(done), 0);
    checkOutput("clr crow hold", 32'(Crow), 2);
    checkOutput("clr cout0 hold", Cout[0], laneVal(0, 300, 2, 0));
    for (int k = 0; k < 2 * DIM - 1; k++) stepAndCheck("postclr", k, 0, 600);

    // Back-to-back with en held high across the boundary
    validCount = 0;
    doneCount  = 0;
    firstDone  = -1;
    secondDone = -1;
    for (int k = 0; k < 2 * (2 * DIM - 1); k++) begin
      stepAndCheck("b2b", k % (2 * DIM - 1), 0, (k < 2 * DIM - 1) ? 0 : 1000);
      if (Cvalid === 1'b1) validCount++;
      if (done === 1'b1) begin
        doneCount++;
        if (firstDone < 0) firstDone = k;
        else secondDone = k;
      end
    end
    checkOutput("b2b valid rows", validCount, 2 * DIM);
    checkOutput("b2b done pulses", doneCount, 2);
    checkOutput("b2b done gap", secondDone - firstDone, 2 * DIM - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
